// File: rtl/apple_spawner_if.sv
`default_nettype none
// ============================================================================
//  Module   : apple_spawner_if
//  Brief    : Request/result bundle between the game FSM and apple_spawner.
//             The seed-load pair exists only when APPLE_SPAWN_SEED_EN is
//             defined.
//  Revision : 1.0  initial release
// ============================================================================
interface apple_spawner_if #(
    parameter int FIELD_SIZE = 300,
    parameter int SBITS      = 7
`ifdef APPLE_SPAWN_SEED_EN
    ,
    parameter int LFSR_W     = 16
`endif
);
    logic                  req;
    logic [FIELD_SIZE-1:0] field;
    logic                  busy;
    logic                  done;
    logic                  full;
    logic [SBITS-1:0]      apple_pos;
`ifdef APPLE_SPAWN_SEED_EN
    logic                  seed_load;
    logic [LFSR_W-1:0]     seed_value;

    modport master (output req, field, seed_load, seed_value,
                    input  busy, done, full, apple_pos);
    modport slave  (input  req, field, seed_load, seed_value,
                    output busy, done, full, apple_pos);
`else
    modport master (output req, field,
                    input  busy, done, full, apple_pos);
    modport slave  (input  req, field,
                    output busy, done, full, apple_pos);
`endif
endinterface
`default_nettype wire

// File: rtl/apple_spawner.sv
`default_nettype none
// ============================================================================
//  Module   : apple_spawner
//  Brief    : Sequential apple placer. On req, picks an LFSR-derived start
//             cell and scans forward one cell per clock (wrapping) to the
//             first empty cell; reports its index or that the field is full.
//             Optional feature macro: APPLE_SPAWN_SEED_EN (LFSR seed loading).
//  Revision : 1.0  initial release
// ============================================================================
module apple_spawner #(
    parameter int SIZE_X     = 10,
    parameter int SIZE_Y     = 10,
    parameter int CELL_BITS  = 3,
    parameter int EMPTY_CODE = 0,
    parameter int LFSR_W     = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    apple_spawner_if.slave   bus
);
    localparam int c_NCELLS = SIZE_X * SIZE_Y;
    localparam int c_SBITS  = $clog2(c_NCELLS);

    localparam logic [c_SBITS-1:0]   c_NCELLS_S  = c_SBITS'(c_NCELLS);
    localparam logic [c_SBITS-1:0]   c_LAST      = c_SBITS'(c_NCELLS - 1);
    localparam logic [LFSR_W-1:0]    c_LFSR_INIT = LFSR_W'(16'hACE1);
    localparam logic [CELL_BITS-1:0] c_EMPTY     = CELL_BITS'(EMPTY_CODE);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SCAN = 1'b1;

    logic [0:0]           r_state, w_state_nxt;
    logic [c_SBITS-1:0]   r_idx,   w_idx_nxt;
    logic [c_SBITS-1:0]   r_cnt,   w_cnt_nxt;
    logic [c_SBITS-1:0]   r_pos,   w_pos_nxt;
    logic                 r_busy,  w_busy_nxt;
    logic                 r_done,  w_done_nxt;
    logic                 r_full,  w_full_nxt;
    logic [LFSR_W-1:0]    r_lfsr,  w_lfsr_adv;
    logic                 w_fb;
    logic [c_SBITS-1:0]   w_raw_start, w_start;
    logic [CELL_BITS-1:0] w_cell;

    // LFSR feedback (x^16+x^14+x^13+x^11+1) and the start cell derived from
    // the pre-edge LFSR value; one subtraction suffices since 2^SBITS < 2*NCELLS
    always_comb begin
        w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
        w_lfsr_adv  = {r_lfsr[LFSR_W-2:0], w_fb};
        w_raw_start = r_lfsr[c_SBITS-1:0];
        w_start     = (w_raw_start >= c_NCELLS_S) ? (w_raw_start - c_NCELLS_S)
                                                  : w_raw_start;
        w_cell      = bus.field[r_idx * CELL_BITS +: CELL_BITS];
    end

    // LFSR advances every clock; a seed load (when built in) overrides it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= c_LFSR_INIT;
`ifdef APPLE_SPAWN_SEED_EN
        end else if (bus.seed_load) begin
            // an all-zero seed would lock the LFSR up
            r_lfsr <= (bus.seed_value == '0) ? c_LFSR_INIT : bus.seed_value;
`endif
        end else begin
            r_lfsr <= w_lfsr_adv;
        end
    end

    // Next-state and output decode for the idle/scan controller
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_pos_nxt   = r_pos;
        w_busy_nxt  = r_busy;
        w_full_nxt  = r_full;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.req) begin
                    w_idx_nxt   = w_start;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_full_nxt  = 1'b0;
                    w_state_nxt = c_ST_SCAN;
                end
            end
            c_ST_SCAN: begin
                if (w_cell == c_EMPTY) begin
                    w_pos_nxt   = r_idx;
                    w_full_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = c_ST_IDLE;
                end else if (r_cnt == c_LAST) begin
                    // every cell visited: keep the old apple position
                    w_full_nxt  = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_idx_nxt   = (r_idx == c_LAST) ? '0 : r_idx + 1'b1;
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Controller state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_pos   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pos   <= w_pos_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_full  <= w_full_nxt;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.full      = r_full;
    assign bus.apple_pos = r_pos;

endmodule
`default_nettype wire
